// File: rtl/led_pwm_fader.sv
// RGB LED driver: decodes a 3-bit {R,G,B} colour code and drives the pins with a
// free-running PWM. Every colour change fades out to dark, swaps, then fades back in.
module led_pwm_fader #(
    parameter int PWM_BITS = 4,
    parameter int STEP     = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] colour,
    output logic [2:0] rgb,
    output logic       busy
);

    localparam int PRE_W = (STEP > 2) ? $clog2(STEP) : 1;

    localparam logic [PWM_BITS-1:0] LEVEL_MAX  = {PWM_BITS{1'b1}};
    localparam logic [PWM_BITS-1:0] LEVEL_ONE  = PWM_BITS'(1);
    localparam logic [PWM_BITS-1:0] LEVEL_ZERO = '0;
    localparam logic [PWM_BITS-1:0] LEVEL_TOP1 = LEVEL_MAX - LEVEL_ONE;
    localparam logic [PRE_W-1:0]    PRE_LAST   = PRE_W'(STEP - 1);
    localparam logic [PRE_W-1:0]    PRE_ONE    = PRE_W'(1);

    typedef enum logic [1:0] {
        ST_STEADY   = 2'd0,
        ST_FADE_OUT = 2'd1,
        ST_SWAP     = 2'd2,
        ST_FADE_IN  = 2'd3
    } state_t;

    state_t              state_reg;
    logic [2:0]          col_q_reg;
    logic [2:0]          active_reg;
    logic [PWM_BITS-1:0] level_reg;
    logic [PWM_BITS-1:0] pwm_cnt_reg;
    logic [PRE_W-1:0]    pre_reg;
    logic [2:0]          rgb_reg;
    logic                busy_reg;

    logic                tick;
    logic                pwm_on;
    logic [2:0]          chan_next;

    assign tick   = (pre_reg == PRE_LAST);
    assign pwm_on = (pwm_cnt_reg < level_reg);

    // Input register and free-running timebase; only reset touches these.
    always_ff @(posedge clk) begin
        if (rst) begin
            col_q_reg   <= 3'b000;
            pwm_cnt_reg <= '0;
            pre_reg     <= '0;
        end else begin
            col_q_reg   <= colour;
            pwm_cnt_reg <= pwm_cnt_reg + LEVEL_ONE;
            pre_reg     <= tick ? '0 : pre_reg + PRE_ONE;
        end
    end

    // Transition sequencer. STEADY always holds level at MAX, so a fade-out
    // always starts from full brightness and takes exactly MAX ticks.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= ST_STEADY;
            active_reg <= 3'b000;
            level_reg  <= LEVEL_MAX;
            busy_reg   <= 1'b0;
        end else begin
            case (state_reg)
                ST_STEADY: begin
                    if (col_q_reg != active_reg) begin
                        busy_reg  <= 1'b1;
                        state_reg <= (active_reg == 3'b000) ? ST_SWAP : ST_FADE_OUT;
                    end
                end
                ST_FADE_OUT: begin
                    if (tick) begin
                        level_reg <= level_reg - LEVEL_ONE;
                        if (level_reg == LEVEL_ONE) begin
                            state_reg <= ST_SWAP;
                        end
                    end
                end
                ST_SWAP: begin
                    // Latest sampled code wins; anything seen mid-fade is dropped.
                    active_reg <= col_q_reg;
                    if (col_q_reg == 3'b000) begin
                        level_reg <= LEVEL_MAX;
                        state_reg <= ST_STEADY;
                        busy_reg  <= 1'b0;
                    end else begin
                        level_reg <= LEVEL_ZERO;
                        state_reg <= ST_FADE_IN;
                    end
                end
                ST_FADE_IN: begin
                    if (tick) begin
                        level_reg <= level_reg + LEVEL_ONE;
                        if (level_reg == LEVEL_TOP1) begin
                            state_reg <= ST_STEADY;
                            busy_reg  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_reg <= ST_STEADY;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_chan
            assign chan_next[gi] = active_reg[gi] & pwm_on;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            rgb_reg <= 3'b000;
        end else begin
            rgb_reg <= chan_next;
        end
    end

    assign rgb  = rgb_reg;
    assign busy = busy_reg;

endmodule

// File: tb/tb_led_pwm_fader.sv
// Directed bench for led_pwm_fader at default parameters (PWM_BITS=4, STEP=4).
module tb_led_pwm_fader;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] colour;
    logic [2:0] rgb;
    logic       busy;

    int checks = 0;
    int passed = 0;

    logic [2:0] trace[$];

    led_pwm_fader #(.PWM_BITS(4), .STEP(4)) dut (
        .clk    (clk),
        .rst    (rst),
        .colour (colour),
        .rgb    (rgb),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Records rgb each cycle after a colour change until busy falls.
    // rise/fall are cycle indices after the change (-1 when never seen).
    task automatic run_transition(input int limit, input int change_at,
                                  input logic [2:0] change_val,
                                  output int rise, output int fall);
        rise = -1;
        fall = -1;
        trace.delete();
        for (int i = 1; i <= limit; i++) begin
            step();
            trace.push_back(rgb);
            if (busy && rise < 0) rise = i;
            if (!busy && rise >= 0) begin
                fall = i;
                break;
            end
            if (i == change_at) colour = change_val;
        end
    endtask

    // Observes 32 cycles (two PWM periods) once the output has settled.
    task automatic measure_steady(input logic [2:0] code, output int on_cnt,
                                  output int dark_cnt, output int busy_cnt);
        on_cnt   = 0;
        dark_cnt = 0;
        busy_cnt = 0;
        step();
        step();
        for (int i = 0; i < 32; i++) begin
            step();
            if (rgb == code) on_cnt++;
            if (rgb == 3'b000) dark_cnt++;
            if (busy) busy_cnt++;
        end
    endtask

    task automatic test_reset();
        int bad_rgb, bad_busy;
        rst    = 1'b1;
        colour = 3'b011;
        step();
        step();
        checks++;
        if (rgb !== 3'b000) $display("FAIL reset_rgb: got %b want 000", rgb);
        else passed++;
        checks++;
        if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy);
        else passed++;
        rst      = 1'b0;
        colour   = 3'b000;
        bad_rgb  = 0;
        bad_busy = 0;
        for (int i = 0; i < 200; i++) begin
            step();
            if (rgb !== 3'b000) bad_rgb++;
            if (busy !== 1'b0) bad_busy++;
        end
        checks++;
        if (bad_rgb != 0) $display("FAIL idle_rgb: %0d lit cycles, want 0", bad_rgb);
        else passed++;
        checks++;
        if (bad_busy != 0) $display("FAIL idle_busy: %0d busy cycles, want 0", bad_busy);
        else passed++;
        $display("test_reset done");
    endtask

    task automatic test_power_up();
        int rise, fall, wrong, on_cnt, dark_cnt, busy_cnt;
        colour = 3'b001;
        run_transition(300, 0, 3'b000, rise, fall);
        checks++;
        if (rise != 2) $display("FAIL pu_busy_rise: cycle %0d want 2", rise);
        else passed++;
        // Sample+FSM (2) + SWAP (1) + 57..60 for 15 ticks, plus slack to 65.
        checks++;
        if (fall < 60 || fall > 65) $display("FAIL pu_busy_fall: cycle %0d want 60..65", fall);
        else passed++;
        wrong = 0;
        foreach (trace[j]) if (trace[j][2:1] != 2'b00) wrong++;
        checks++;
        if (wrong != 0) $display("FAIL pu_rg_lit: %0d cycles with R/G, want 0", wrong);
        else passed++;
        measure_steady(3'b001, on_cnt, dark_cnt, busy_cnt);
        checks++;
        if (on_cnt != 30) $display("FAIL pu_duty: on %0d/32 want 30", on_cnt);
        else passed++;
        checks++;
        if (dark_cnt != 2) $display("FAIL pu_dark: dark %0d/32 want 2", dark_cnt);
        else passed++;
        $display("test_power_up rise=%0d fall=%0d on=%0d", rise, fall, on_cnt);
    endtask

    task automatic test_cross_fade();
        int rise, fall, last_b, first_rg, both, run, max_run, found;
        int on_cnt, dark_cnt, busy_cnt;
        // A dark sample at steady MAX marks pwm_cnt wrapping to 0; launching
        // 4 cycles later puts the lowest levels in unlit PWM slots.
        found = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (rgb == 3'b000) begin
                found = 1;
                break;
            end
        end
        checks++;
        if (found != 1) $display("FAIL xf_sync: no dark slot seen, got %0d want 1", found);
        else passed++;
        repeat (4) step();
        colour = 3'b110;
        run_transition(300, 0, 3'b000, rise, fall);
        checks++;
        if (rise != 2) $display("FAIL xf_busy_rise: cycle %0d want 2", rise);
        else passed++;
        checks++;
        if (fall < 0 || (fall - rise) < 118 || (fall - rise) > 121)
            $display("FAIL xf_busy_len: %0d cycles want 118..121", fall - rise);
        else passed++;
        last_b   = -1;
        first_rg = -1;
        both     = 0;
        run      = 0;
        max_run  = 0;
        foreach (trace[j]) begin
            if (trace[j][0]) last_b = j;
            if (trace[j][2:1] != 2'b00 && first_rg < 0) first_rg = j;
            if (trace[j][0] && trace[j][2:1] != 2'b00) both++;
            if (trace[j] == 3'b000) begin
                run++;
                if (run > max_run) max_run = run;
            end else begin
                run = 0;
            end
        end
        checks++;
        if (last_b < 0 || first_rg <= last_b || both != 0)
            $display("FAIL xf_order: last blue %0d first rg %0d mixed %0d, want blue before rg",
                     last_b, first_rg, both);
        else passed++;
        checks++;
        if (max_run < 16) $display("FAIL xf_dark_window: %0d cycles want >=16", max_run);
        else passed++;
        measure_steady(3'b110, on_cnt, dark_cnt, busy_cnt);
        checks++;
        if (on_cnt != 30) $display("FAIL xf_duty: on %0d/32 want 30", on_cnt);
        else passed++;
        $display("test_cross_fade len=%0d dark_run=%0d", fall - rise, max_run);
    endtask

    task automatic test_mid_fade_change();
        int rise, fall, bad, seen_r;
        int on_cnt, dark_cnt, busy_cnt;
        colour = 3'b010;
        run_transition(300, 12, 3'b100, rise, fall);
        checks++;
        if (rise != 2) $display("FAIL mid_busy_rise: cycle %0d want 2", rise);
        else passed++;
        checks++;
        if (fall < 0 || (fall - rise) < 117 || (fall - rise) > 121)
            $display("FAIL mid_busy_len: %0d cycles want 117..121", fall - rise);
        else passed++;
        bad    = 0;
        seen_r = 0;
        foreach (trace[j]) begin
            if (trace[j] == 3'b100) seen_r = 1;
            if (trace[j] == 3'b010 || (seen_r != 0 && trace[j][1])) bad++;
        end
        checks++;
        if (bad != 0) $display("FAIL mid_green: %0d cycles show 010 code, want 0", bad);
        else passed++;
        measure_steady(3'b100, on_cnt, dark_cnt, busy_cnt);
        checks++;
        if (on_cnt != 30 || dark_cnt != 2)
            $display("FAIL mid_final: red %0d dark %0d want 30/2", on_cnt, dark_cnt);
        else passed++;
        checks++;
        if (busy_cnt != 0) $display("FAIL mid_no_retrigger: busy %0d cycles want 0", busy_cnt);
        else passed++;
        $display("test_mid_fade_change len=%0d", fall - rise);
    endtask

    task automatic test_fade_off();
        int rise, fall, bad, lit, hi;
        colour = 3'b000;
        run_transition(300, 0, 3'b000, rise, fall);
        checks++;
        if (rise != 2) $display("FAIL off_busy_rise: cycle %0d want 2", rise);
        else passed++;
        checks++;
        if (fall < 58 || fall > 66) $display("FAIL off_busy_fall: cycle %0d want 58..66", fall);
        else passed++;
        bad = 0;
        foreach (trace[j]) if (trace[j] != 3'b000 && trace[j] != 3'b100) bad++;
        checks++;
        if (bad != 0) $display("FAIL off_trace: %0d foreign codes want 0", bad);
        else passed++;
        lit = 0;
        hi  = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (rgb != 3'b000) lit++;
            if (busy) hi++;
        end
        checks++;
        if (lit != 0 || hi != 0) $display("FAIL off_dark: lit %0d busy %0d want 0/0", lit, hi);
        else passed++;
        $display("test_fade_off fall=%0d", fall);
    endtask

    task automatic test_reset_mid_fade();
        int rise, fall, on_cnt, dark_cnt, busy_cnt;
        colour = 3'b011;
        repeat (20) step();
        checks++;
        if (busy !== 1'b1) $display("FAIL rmf_in_fade: busy %b want 1", busy);
        else passed++;
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (rgb !== 3'b000 || busy !== 1'b0)
            $display("FAIL rmf_reset: rgb %b busy %b want 000/0", rgb, busy);
        else passed++;
        run_transition(300, 0, 3'b000, rise, fall);
        checks++;
        if (rise != 2) $display("FAIL rmf_busy_rise: cycle %0d want 2", rise);
        else passed++;
        checks++;
        if (fall < 60 || fall > 65) $display("FAIL rmf_busy_fall: cycle %0d want 60..65", fall);
        else passed++;
        measure_steady(3'b011, on_cnt, dark_cnt, busy_cnt);
        checks++;
        if (on_cnt != 30 || busy_cnt != 0)
            $display("FAIL rmf_steady: on %0d busy %0d want 30/0", on_cnt, busy_cnt);
        else passed++;
        $display("test_reset_mid_fade fall=%0d on=%0d", fall, on_cnt);
    endtask

    initial begin
        rst    = 1'b1;
        colour = 3'b000;
        test_reset();
        test_power_up();
        test_cross_fade();
        test_mid_fade_change();
        test_fade_off();
        test_reset_mid_fade();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
